stage_sequencer: RTL and testbench

Single-clock, parametrised stage-strobe generator for the multi-cycle LEGv8 datapath. It replaces the fixed-delay derived clocks (fetch, decode-read, memory, write-back) with synchronous one-hot stage-active levels and stage-done strobes. Stage count and per-stage cycle budgets are configurable. The block adds three behaviours: a memory-ready wait, a global stall, and early instruction retirement for instructions that skip later stages (stores, branches). It sits at datapath top level and drives the enables of fetch, iDecode, iExecute, iMemory and iWrite_back.

---
 rtl/stage_sequencer.sv | 116 +++++++++++
 tb/tb_stage_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/stage_sequencer.sv
// Stage-strobe sequencer for the multi-cycle LEGv8 datapath: one-hot stage levels,
// Mealy done strobes, memory-ready wait, global stall and early retirement.

module stage_slot #(
  parameter int               CNT_W  = 4,
  parameter int               IDX_W  = 3,
  parameter int               IDX    = 0,
  parameter logic [CNT_W-1:0] BUDGET = '0
) (
  input  logic [IDX_W-1:0] cur_stage,
  input  logic             advance,
  output logic [CNT_W-1:0] load,
  output logic             done
);
  // A zero budget still occupies one cycle.
  localparam logic [CNT_W-1:0] EFF = (BUDGET == '0) ? CNT_W'(1) : BUDGET;

  assign load = EFF - CNT_W'(1);
  assign done = advance && (cur_stage == IDX_W'(IDX));
endmodule

module stage_sequencer #(
  parameter int                          NUM_STAGES   = 5,
  parameter int                          CNT_W        = 4,
  parameter logic [NUM_STAGES*CNT_W-1:0] STAGE_CYCLES = 20'h11111,
  parameter int                          MEM_STAGE    = 3,
  localparam int                         IDX_W        = $clog2(NUM_STAGES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  stall,
  input  logic                  mem_ready,
  input  logic                  skip_rest,
  output logic [NUM_STAGES-1:0] stage_active,
  output logic [IDX_W-1:0]      cur_stage,
  output logic [NUM_STAGES-1:0] stage_done,
  output logic                  instr_done,
  output logic                  busy,
  output logic [31:0]           instr_count
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t                               state;
  logic [CNT_W-1:0]                     cnt;
  logic [NUM_STAGES-1:0][CNT_W-1:0]     load;
  logic                                 mem_ok, advance, last;
  logic [IDX_W-1:0]                     nxt_stage;

  assign mem_ok     = (cur_stage != IDX_W'(MEM_STAGE)) || mem_ready;
  assign advance    = (state == RUN) && !stall && (cnt == '0) && mem_ok;
  assign last       = (cur_stage == IDX_W'(NUM_STAGES-1)) || skip_rest;
  assign instr_done = advance && last;
  assign nxt_stage  = cur_stage + IDX_W'(1);

  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_slot
    stage_slot #(
      .CNT_W (CNT_W),
      .IDX_W (IDX_W),
      .IDX   (i),
      .BUDGET(STAGE_CYCLES[i*CNT_W +: CNT_W])
    ) u_slot (
      .cur_stage(cur_stage),
      .advance  (advance),
      .load     (load[i]),
      .done     (stage_done[i])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cur_stage    <= '0;
      cnt          <= '0;
      instr_count  <= '0;
      stage_active <= '0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: if (run) begin
          state        <= RUN;
          cur_stage    <= '0;
          cnt          <= load[0];
          stage_active <= NUM_STAGES'(1);
          busy         <= 1'b1;
        end
        RUN: if (!stall) begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (advance) begin
            if (last) begin
              instr_count <= instr_count + 32'd1;
              // Back-to-back instructions restart at stage 0 with no bubble.
              if (run) begin
                cur_stage    <= '0;
                cnt          <= load[0];
                stage_active <= NUM_STAGES'(1);
              end else begin
                state        <= IDLE;
                cur_stage    <= '0;
                cnt          <= '0;
                stage_active <= '0;
                busy         <= 1'b0;
              end
            end else begin
              cur_stage    <= nxt_stage;
              cnt          <= load[nxt_stage];
              stage_active <= stage_active << 1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: default budgets plus a non-uniform budget instance.

module tb_stage_sequencer;
  localparam int NS = 5;
  localparam int IW = 3;

  logic clk = 1'b0, reset = 1'b1, run = 1'b0, stall = 1'b0, mem_ready = 1'b1, skip_rest = 1'b0;
  logic [NS-1:0] sa_a, sd_a, sa_b, sd_b;
  logic [IW-1:0] cs_a, cs_b;
  logic          id_a, id_b, busy_a, busy_b;
  logic [31:0]   ic_a, ic_b;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  stage_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .stall(stall), .mem_ready(mem_ready),
    .skip_rest(skip_rest), .stage_active(sa_a), .cur_stage(cs_a), .stage_done(sd_a),
    .instr_done(id_a), .busy(busy_a), .instr_count(ic_a)
  );

  stage_sequencer #(.STAGE_CYCLES(20'h31211)) dut_b (
    .clk(clk), .reset(reset), .run(run), .stall(stall), .mem_ready(mem_ready),
    .skip_rest(skip_rest), .stage_active(sa_b), .cur_stage(cs_b), .stage_done(sd_b),
    .instr_done(id_b), .busy(busy_b), .instr_count(ic_b)
  );

  task automatic do_reset;
    @(negedge clk);
    run = 0; stall = 0; skip_rest = 0; mem_ready = 1; reset = 0;
    @(negedge clk);
    reset = 1;
  endtask

  task automatic test_reset;
    #1 reset = 0;
    #1;
    checks++;
    if ({sa_a, sd_a, id_a, busy_a, cs_a} !== '0) begin
      failures++; $display("FAIL reset_outputs got=%b exp=0", {sa_a, sd_a, id_a, busy_a, cs_a});
    end
    checks++;
    if (ic_a !== 32'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", ic_a); end
    @(negedge clk); reset = 1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); #1;
      checks++;
      if (busy_a !== 1'b0 || sa_a !== '0) begin
        failures++; $display("FAIL idle_after_reset cyc=%0d busy=%b active=%b exp 0", c, busy_a, sa_a);
      end
    end
  endtask

  task automatic test_defaults;
    logic [NS-1:0] e;
    do_reset();
    @(negedge clk); run = 1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk); #1;
      e = 5'b00001 << ((c - 1) % 5);
      checks++;
      if (sa_a !== e) begin failures++; $display("FAIL dflt_active cyc=%0d got=%b exp=%b", c, sa_a, e); end
      checks++;
      if (sd_a !== e) begin failures++; $display("FAIL dflt_done cyc=%0d got=%b exp=%b", c, sd_a, e); end
      checks++;
      if (id_a !== (c % 5 == 0)) begin failures++; $display("FAIL dflt_instr_done cyc=%0d got=%b", c, id_a); end
      checks++;
      if (ic_a !== 32'((c - 1) / 5)) begin
        failures++; $display("FAIL dflt_count cyc=%0d got=%0d exp=%0d", c, ic_a, (c - 1) / 5);
      end
      checks++;
      if (busy_a !== 1'b1) begin failures++; $display("FAIL dflt_busy cyc=%0d got=%b exp=1", c, busy_a); end
    end
  endtask

  task automatic test_budgets;
    int            st[8] = '{0, 1, 2, 2, 3, 4, 4, 4};
    logic [NS-1:0] dn[8] = '{5'd1, 5'd2, 5'd0, 5'd4, 5'd8, 5'd0, 5'd0, 5'd16};
    do_reset();
    @(negedge clk); run = 1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk); #1;
      checks++;
      if (cs_b !== IW'(st[c-1]) || sa_b !== (5'b00001 << st[c-1])) begin
        failures++; $display("FAIL budget_stage cyc=%0d got=%0d/%b exp=%0d", c, cs_b, sa_b, st[c-1]);
      end
      checks++;
      if (sd_b !== dn[c-1]) begin failures++; $display("FAIL budget_done cyc=%0d got=%b exp=%b", c, sd_b, dn[c-1]); end
      checks++;
      if (id_b !== (c == 8)) begin failures++; $display("FAIL budget_instr_done cyc=%0d got=%b", c, id_b); end
    end
    @(negedge clk); #1;
    checks++;
    if (sa_b !== 5'b00001 || ic_b !== 32'd1) begin
      failures++; $display("FAIL budget_restart got=%b/%0d exp=00001/1", sa_b, ic_b);
    end
  endtask

  task automatic test_mem_wait;
    int            st[8] = '{0, 1, 2, 3, 3, 3, 3, 4};
    logic [NS-1:0] dn[8] = '{5'd1, 5'd2, 5'd4, 5'd0, 5'd0, 5'd0, 5'd8, 5'd16};
    do_reset();
    @(negedge clk); run = 1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      mem_ready = (c < 4 || c > 6);
      #1;
      checks++;
      if (cs_a !== IW'(st[c-1]) || sa_a !== (5'b00001 << st[c-1])) begin
        failures++; $display("FAIL mem_stage cyc=%0d got=%0d/%b exp=%0d", c, cs_a, sa_a, st[c-1]);
      end
      checks++;
      if (sd_a !== dn[c-1]) begin failures++; $display("FAIL mem_done cyc=%0d got=%b exp=%b", c, sd_a, dn[c-1]); end
      checks++;
      if (id_a !== (c == 8)) begin failures++; $display("FAIL mem_instr_done cyc=%0d got=%b", c, id_a); end
    end
    mem_ready = 1;
  endtask

  task automatic test_stall;
    int            st[7] = '{0, 1, 2, 2, 2, 3, 4};
    logic [NS-1:0] dn[7] = '{5'd1, 5'd2, 5'd0, 5'd0, 5'd4, 5'd8, 5'd16};
    do_reset();
    @(negedge clk); run = 1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      stall = (c == 3 || c == 4);
      #1;
      checks++;
      if (cs_a !== IW'(st[c-1])) begin failures++; $display("FAIL stall_stage cyc=%0d got=%0d exp=%0d", c, cs_a, st[c-1]); end
      checks++;
      if (sd_a !== dn[c-1]) begin failures++; $display("FAIL stall_done cyc=%0d got=%b exp=%b", c, sd_a, dn[c-1]); end
      checks++;
      if (id_a !== (c == 7)) begin failures++; $display("FAIL stall_instr_done cyc=%0d got=%b", c, id_a); end
    end
    stall = 0;
  endtask

  task automatic test_skip_rest;
    int st[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    do_reset();
    @(negedge clk); run = 1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      skip_rest = (c == 4);
      #1;
      checks++;
      if (sa_a !== (5'b00001 << st[c-1]) || sd_a !== (5'b00001 << st[c-1])) begin
        failures++; $display("FAIL skip_stage cyc=%0d got=%b/%b exp stage %0d", c, sa_a, sd_a, st[c-1]);
      end
      checks++;
      if (id_a !== (c == 4)) begin failures++; $display("FAIL skip_instr_done cyc=%0d got=%b", c, id_a); end
      checks++;
      if (ic_a !== 32'(c >= 5)) begin failures++; $display("FAIL skip_count cyc=%0d got=%0d", c, ic_a); end
    end
    skip_rest = 0;
  endtask

  task automatic test_reset_mid;
    do_reset();
    @(negedge clk); run = 1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk); #1;
    end
    checks++;
    if (sa_a !== 5'b00100 || ic_a !== 32'd2) begin
      failures++; $display("FAIL mid_pre got=%b/%0d exp=00100/2", sa_a, ic_a);
    end
    reset = 0;
    #1;
    checks++;
    if ({sa_a, sd_a, id_a, busy_a, cs_a} !== '0 || ic_a !== 32'd0) begin
      failures++; $display("FAIL mid_reset got=%b/%0d exp=0/0", {sa_a, sd_a, id_a, busy_a, cs_a}, ic_a);
    end
    @(negedge clk); run = 0;
    @(negedge clk); reset = 1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); #1;
      checks++;
      if (busy_a !== 1'b0 || ic_a !== 32'd0) begin
        failures++; $display("FAIL mid_idle cyc=%0d busy=%b count=%0d exp 0/0", c, busy_a, ic_a);
      end
    end
    run = 1;
    @(negedge clk); #1;
    checks++;
    if (sa_a !== 5'b00001 || busy_a !== 1'b1 || cs_a !== 3'd0) begin
      failures++; $display("FAIL mid_restart got=%b/%b/%0d exp=00001/1/0", sa_a, busy_a, cs_a);
    end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_budgets();
    test_mem_wait();
    test_stall();
    test_skip_rest();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
